poly_synth_wrapper: RTL and testbench

- Parametrised polyphonic successor to the single-voice synth wrapper.
- Samples NUM_KEYS key inputs from the breakout GPIO and allocates pressed keys to NUM_VOICES square-wave voices.
- Mixes the active voices and drives one PWM audio pin.
- Sits directly under the Caravel user-project top; owns the 34-bit GPIO in/out/oeb bundle.

---
 rtl/poly_synth_wrapper.sv | 225 ++++++++++++++++++++++
 tb/tb_poly_synth_wrapper.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_synth_wrapper.sv
// Polyphonic square-wave synth: GPIO keys -> voices -> mixed level -> one PWM pin.
// Optional POLY_SYNTH_VOICE_STEAL_EN lets a waiting key steal the oldest voice when all are busy.
module poly_synth_wrapper #(
  parameter int NUM_KEYS    = 16,
  parameter int NUM_VOICES  = 4,
  parameter int PWM_BITS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int BASE_HALF   = 400,
  parameter int STEP_HALF   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ncs,
  input  logic [33:0] gpio_in,
  output logic [33:0] gpio_out,
  output logic [33:0] gpio_oeb
);

  localparam int KW         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int HW         = $clog2(BASE_HALF + 1);
  localparam int SW         = $clog2(NUM_VOICES + 1);
  localparam int LEVEL_STEP = ((2 ** PWM_BITS) - 1) / NUM_VOICES;

  logic [SYNC_STAGES-1:0][NUM_KEYS-1:0] key_sync_r;
  logic [SYNC_STAGES-1:0]               ncs_sync_r;
  logic                                 ncs_s;
  logic [NUM_KEYS-1:0]                  pressed_s;
  logic [NUM_KEYS-1:0]                  held_s;
  logic [NUM_KEYS-1:0]                  avail_s;
  logic                                 cand_found_s;
  logic                                 free_found_s;
  logic                                 load_s;
  logic [KW-1:0]                        cand_s;
  logic [VW-1:0]                        free_s;
  logic [VW-1:0]                        tgt_s;
  logic [NUM_VOICES-1:0]                valid_r;
  logic [NUM_VOICES-1:0]                valid_s;
  logic [NUM_VOICES-1:0]                sq_r;
  logic [NUM_VOICES-1:0]                sq_s;
  logic [KW-1:0]                        key_r [NUM_VOICES];
  logic [KW-1:0]                        key_s [NUM_VOICES];
  logic [HW-1:0]                        cnt_r [NUM_VOICES];
  logic [HW-1:0]                        cnt_s [NUM_VOICES];
  logic [SW-1:0]                        sum_s;
  logic [PWM_BITS-1:0]                  level_s;
  logic [PWM_BITS-1:0]                  level_r;
  logic [PWM_BITS-1:0]                  latched_r;
  logic [PWM_BITS-1:0]                  level_eff_s;
  logic [PWM_BITS-1:0]                  pwm_cnt_r;
  logic                                 pwm_r;
  logic                                 active_r;
  logic                                 unused_gpio_s;
`ifdef POLY_SYNTH_VOICE_STEAL_EN
  logic [2:0]                           age_r [NUM_VOICES];
  logic [2:0]                           age_s [NUM_VOICES];
  logic [2:0]                           best_s;
  logic [VW-1:0]                        victim_s;
  logic                                 steal_s;
  logic [NUM_KEYS-1:0]                  stolen_r;
  logic [NUM_KEYS-1:0]                  stolen_s;
`endif

  function automatic logic [HW-1:0] half_of(input logic [KW-1:0] k);
    return HW'(BASE_HALF - (int'(k) * STEP_HALF));
  endfunction

  assign ncs_s         = ncs_sync_r[SYNC_STAGES-1];
  assign pressed_s     = key_sync_r[SYNC_STAGES-1] & {NUM_KEYS{~ncs_s}};
  assign unused_gpio_s = ^gpio_in[33:NUM_KEYS];

  // Synchroniser chains for the asynchronous keys and chip select.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_sync_r <= {(SYNC_STAGES * NUM_KEYS){1'b0}};
      ncs_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      key_sync_r <= {key_sync_r[SYNC_STAGES-2:0], gpio_in[NUM_KEYS-1:0]};
      ncs_sync_r <= {ncs_sync_r[SYNC_STAGES-2:0], ncs};
    end
  end

  // Pick the lowest unvoiced pressed key and the voice it should land on.
  always_comb begin
    held_s = {NUM_KEYS{1'b0}};
    for (int v = 0; v < NUM_VOICES; v++) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        held_s[k] = held_s[k] | (valid_r[v] & (key_r[v] == KW'(k)));
      end
    end
`ifdef POLY_SYNTH_VOICE_STEAL_EN
    avail_s = pressed_s & ~held_s & ~stolen_r;
`else
    avail_s = pressed_s & ~held_s;
`endif
    cand_found_s = |avail_s;
    cand_s       = {KW{1'b0}};
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      cand_s = avail_s[k] ? KW'(k) : cand_s;
    end
    free_found_s = ~&valid_r;
    free_s       = {VW{1'b0}};
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      free_s = valid_r[v] ? free_s : VW'(v);
    end
`ifdef POLY_SYNTH_VOICE_STEAL_EN
    // Oldest voice wins; strict compare keeps the lowest index on ties.
    victim_s = {VW{1'b0}};
    best_s   = age_r[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      victim_s = (age_r[v] > best_s) ? VW'(v) : victim_s;
      best_s   = (age_r[v] > best_s) ? age_r[v] : best_s;
    end
    steal_s = cand_found_s & ~free_found_s;
    load_s  = cand_found_s;
    tgt_s   = free_found_s ? free_s : victim_s;
`else
    load_s  = cand_found_s & free_found_s;
    tgt_s   = free_s;
`endif
  end

  // Per-voice next state: allocation, release, oscillator.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      valid_s[v] = valid_r[v];
      key_s[v]   = key_r[v];
      cnt_s[v]   = cnt_r[v];
      sq_s[v]    = sq_r[v];
      if (load_s && (tgt_s == VW'(v))) begin
        valid_s[v] = 1'b1;
        key_s[v]   = cand_s;
        cnt_s[v]   = half_of(cand_s);
        sq_s[v]    = 1'b0;
      end else if (valid_r[v] && !pressed_s[key_r[v]]) begin
        valid_s[v] = 1'b0;
        sq_s[v]    = 1'b0;
      end else if (valid_r[v] && (cnt_r[v] == HW'(1'b1))) begin
        sq_s[v]    = ~sq_r[v];
        cnt_s[v]   = half_of(key_r[v]);
      end else if (valid_r[v]) begin
        cnt_s[v]   = cnt_r[v] - HW'(1'b1);
      end else begin
        cnt_s[v]   = cnt_r[v];
      end
    end
`ifdef POLY_SYNTH_VOICE_STEAL_EN
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (load_s && (tgt_s == VW'(v))) begin
        age_s[v] = 3'd0;
      end else if (load_s && valid_s[v] && (age_r[v] != 3'd7)) begin
        age_s[v] = age_r[v] + 3'd1;
      end else begin
        age_s[v] = age_r[v];
      end
    end
    // A key that lost its voice stays silent until it is released.
    for (int k = 0; k < NUM_KEYS; k++) begin
      stolen_s[k] = (stolen_r[k] & pressed_s[k]) | (steal_s & (key_r[victim_s] == KW'(k)));
    end
`endif
  end

  // Mixer sum and the PWM compare level for the current counter value.
  always_comb begin
    sum_s = {SW{1'b0}};
    for (int v = 0; v < NUM_VOICES; v++) begin
      sum_s = sum_s + SW'(valid_r[v] & sq_r[v]);
    end
    level_s     = ncs_s ? {PWM_BITS{1'b0}} : PWM_BITS'(int'(sum_s) * LEVEL_STEP);
    level_eff_s = (pwm_cnt_r == {PWM_BITS{1'b0}}) ? level_r : latched_r;
  end

  // Voice state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {NUM_VOICES{1'b0}};
      sq_r    <= {NUM_VOICES{1'b0}};
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_r[v] <= {KW{1'b0}};
        cnt_r[v] <= {HW{1'b0}};
      end
`ifdef POLY_SYNTH_VOICE_STEAL_EN
      for (int v = 0; v < NUM_VOICES; v++) begin
        age_r[v] <= 3'd0;
      end
      stolen_r <= {NUM_KEYS{1'b0}};
`endif
    end else begin
      valid_r <= valid_s;
      sq_r    <= sq_s;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_r[v] <= key_s[v];
        cnt_r[v] <= cnt_s[v];
      end
`ifdef POLY_SYNTH_VOICE_STEAL_EN
      for (int v = 0; v < NUM_VOICES; v++) begin
        age_r[v] <= age_s[v];
      end
      stolen_r <= stolen_s;
`endif
    end
  end

  // Level, glitch-free PWM latch/compare and the activity flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_r   <= {PWM_BITS{1'b0}};
      latched_r <= {PWM_BITS{1'b0}};
      pwm_cnt_r <= {PWM_BITS{1'b0}};
      pwm_r     <= 1'b0;
      active_r  <= 1'b0;
    end else begin
      level_r   <= level_s;
      latched_r <= level_eff_s;
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1'b1);
      pwm_r     <= (pwm_cnt_r < level_eff_s);
      active_r  <= |valid_s;
    end
  end

  assign gpio_out = {pwm_r, active_r, 32'h0000_0000};
  assign gpio_oeb = {2'b00, {32{1'b1}}};

endmodule

// File: tb/tb_poly_synth_wrapper.sv
// Self-checking bench for poly_synth_wrapper: directed scenarios plus random key/ncs traffic
// compared cycle by cycle with a timestamp-based behavioural model.
module tb_poly_synth_wrapper;

  localparam int NK   = 16;
  localparam int NV   = 4;
  localparam int PB   = 8;
  localparam int SS   = 2;
  localparam int BH   = 400;
  localparam int SH   = 20;
  localparam int STEP = ((1 << PB) - 1) / NV;

  logic        clk = 1'b0;
  logic        rst;
  logic        ncs;
  logic [33:0] gpio_in;
  logic [33:0] gpio_out;
  logic [33:0] gpio_oeb;

  int checks   = 0;
  int failures = 0;

  poly_synth_wrapper dut (
    .clk      (clk),
    .rst      (rst),
    .ncs      (ncs),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oeb (gpio_oeb)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Behavioural model: voices remember the edge they were allocated on; square is derived arithmetically.
  logic [NK-1:0] key_delay[$];
  logic          ncs_delay[$];
  bit            m_valid  [NV];
  int            m_key    [NV];
  int            m_start  [NV];
  int            m_age    [NV];
  bit            m_stolen [NK];
  int            m_n;
  int            m_level;
  int            m_latched;
  bit            m_pwm;
  bit            m_active;

  function automatic int hp(input int k);
    return BH - k * SH;
  endfunction

  function automatic bit sq_of(input int v, input int t);
    return (((t - m_start[v]) / hp(m_key[v])) % 2) == 1;
  endfunction

  function automatic void model_reset();
    key_delay.delete();
    ncs_delay.delete();
    for (int i = 0; i < SS; i++) begin
      key_delay.push_back('0);
      ncs_delay.push_back(1'b0);
    end
    for (int v = 0; v < NV; v++) begin
      m_valid[v] = 0; m_key[v] = 0; m_start[v] = 0; m_age[v] = 0;
    end
    for (int k = 0; k < NK; k++) m_stolen[k] = 0;
    m_n = 0; m_level = 0; m_latched = 0; m_pwm = 0; m_active = 0;
  endfunction

  function automatic void model_alloc(input int tv, input int k);
    for (int v = 0; v < NV; v++) begin
      if (v != tv && m_valid[v] && m_age[v] < 7) m_age[v]++;
    end
    m_valid[tv] = 1; m_key[tv] = k; m_start[tv] = m_n; m_age[tv] = 0;
  endfunction

  function automatic void model_edge();
    logic [NK-1:0] keys_s;
    logic          ncs_s;
    logic [NK-1:0] pressed;
    bit            held [NK];
    int            sq_cnt, c, eff, cand, target, victim;
    if (rst) begin
      model_reset();
      return;
    end
    keys_s = key_delay.pop_front();
    ncs_s  = ncs_delay.pop_front();
    key_delay.push_back(gpio_in[NK-1:0]);
    ncs_delay.push_back(ncs);
    pressed = ncs_s ? '0 : keys_s;
    m_n++;
    sq_cnt = 0;
    for (int v = 0; v < NV; v++) if (m_valid[v] && sq_of(v, m_n - 1)) sq_cnt++;
    c         = (m_n - 1) % (1 << PB);
    eff       = (c == 0) ? m_level : m_latched;
    m_latched = eff;
    m_pwm     = (c < eff);
    m_level   = ncs_s ? 0 : sq_cnt * STEP;
    for (int k = 0; k < NK; k++) held[k] = 0;
    for (int v = 0; v < NV; v++) if (m_valid[v]) held[m_key[v]] = 1;
    cand = -1;
    for (int k = 0; k < NK; k++) if (cand < 0 && pressed[k] && !held[k] && !m_stolen[k]) cand = k;
    target = -1;
    for (int v = 0; v < NV; v++) if (target < 0 && !m_valid[v]) target = v;
    victim = 0;
    for (int v = 1; v < NV; v++) if (m_age[v] > m_age[victim]) victim = v;
    for (int v = 0; v < NV; v++) if (m_valid[v] && !pressed[m_key[v]]) m_valid[v] = 0;
    for (int k = 0; k < NK; k++) m_stolen[k] = m_stolen[k] && pressed[k];
    if (cand >= 0 && target >= 0) begin
      model_alloc(target, cand);
    end
`ifdef POLY_SYNTH_VOICE_STEAL_EN
    else if (cand >= 0) begin
      m_stolen[m_key[victim]] = 1;
      model_alloc(victim, cand);
    end
`endif
    m_active = 0;
    for (int v = 0; v < NV; v++) if (m_valid[v]) m_active = 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("gpio_out", 64'(gpio_out), 64'({m_pwm, m_active, 32'h0}));
  endtask

  initial begin
    int hi;
    int n_a;
    rst     = 1'b1;
    ncs     = 1'b0;
    gpio_in = '0;
    model_reset();
    repeat (5) tick();
    check_eq("reset_out", 64'(gpio_out), 64'd0);
    check_eq("oeb", 64'(gpio_oeb), 64'h0_FFFF_FFFF);
    rst = 1'b0;
    hi  = 0;
    repeat (1024) begin tick(); hi += int'(gpio_out[33]); end
    check_eq("idle_pwm_highs", 64'(hi), 64'd0);

    // Single key: allocation latency and full-scale-quarter duty while square is high.
    gpio_in = 34'd1;
    tick(); tick();
    check_eq("key0_before_alloc", 64'(gpio_out[32]), 64'd0);
    tick();
    check_eq("key0_alloc", 64'(gpio_out[32]), 64'd1);
    n_a = m_n;
    while (!(((m_n % (1 << PB)) == 0) && (m_n + 1 >= n_a + 402))) tick();
    hi = 0;
    repeat (1 << PB) begin tick(); hi += int'(gpio_out[33]); end
    check_eq("key0_duty", 64'(hi), 64'(STEP));
    repeat (300) tick();
    gpio_in = '0;
    repeat (20) tick();

    // Two keys pressed together, then five keys against four voices with a release.
    gpio_in = 34'h88;
    repeat (1000) tick();
    gpio_in = '0;
    repeat (10) tick();
    gpio_in = 34'h1F;
    repeat (600) tick();
    gpio_in = 34'h1D;
    repeat (600) tick();

    // Deselect with three voices playing.
    gpio_in = 34'h7;
    repeat (900) tick();
    ncs = 1'b1;
    tick(); tick();
    check_eq("ncs_still_active", 64'(gpio_out[32]), 64'd1);
    tick();
    check_eq("ncs_silenced", 64'(gpio_out[32]), 64'd0);
    repeat (344) tick();
    hi = 0;
    repeat (1 << PB) begin tick(); hi += int'(gpio_out[33]); end
    check_eq("ncs_pwm_quiet", 64'(hi), 64'd0);
    ncs = 1'b0;
    repeat (900) tick();
    rst = 1'b1;
    tick();
    check_eq("rst_mid_note", 64'(gpio_out), 64'd0);
    rst = 1'b0;

    // Random key patterns, upper GPIO noise, occasional deselect and reset.
    for (int s = 0; s < 25; s++) begin
      gpio_in          = 34'({$urandom, $urandom});
      gpio_in[NK-1:0]  = NK'($urandom & $urandom & $urandom);
      ncs              = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      repeat ($urandom_range(200, 1500)) tick();
    end
    check_eq("oeb_end", 64'(gpio_oeb), 64'h0_FFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
